sram_ctrl: RTL and testbench

Memory-stage controller that sequences one 32-bit ARM load/store into two 16-bit accesses on the external SRAM bus (19-bit address, 16-bit bidirectional DQ). Sits between the MEM stage of the ARM pipeline and the SRAM device. Holds `ready` low while an access is in progress so the hazard/freeze logic stalls the whole pipeline.

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_phase_counter.sv | 28 ++
 rtl/sram_ctrl.sv | 114 +++++++++++
 tb/tb_sram_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and state encoding for the 32-bit to 2x16-bit SRAM access sequencer.
package sram_ctrl_pkg;

  localparam int          SRAM_AW           = 19;
  localparam int          SRAM_DW           = 16;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOW  = 2'd1;
  localparam state_t ST_HIGH = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Half-word bus address: latched 32-bit word index plus half select.
  function automatic logic [SRAM_AW-1:0] half_addr(input logic [SRAM_AW-2:0] word,
                                                   input logic half);
    return {word, half};
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Modulo-ACCESS_CYCLES counter timing each half-access; o_tc marks the last cycle of a phase.
module sram_phase_counter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(ACCESS_CYCLES - 1));
  assign o_tc   = i_en && w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Sequences one 32-bit load/store as low then high 16-bit SRAM accesses, freezing the pipeline
// via ready until DONE. All bus-facing outputs are registered.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  state_t             r_state;
  logic               r_write;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_addr;
  logic               r_we_n;
  logic               r_dq_oe;
  logic [SRAM_DW-1:0] r_dq_out;

  logic [31:0] w_offset;
  logic        w_req;
  logic        w_in_phase;
  logic        w_tc;
  logic        w_unused_offset_bits;

  assign w_req      = wr_en | rd_en;
  assign w_offset   = address - BASE_ADDR;
  assign w_in_phase = (r_state == ST_LOW) || (r_state == ST_HIGH);
  // Byte-lane bits and bits beyond the SRAM range are deliberately dropped.
  assign w_unused_offset_bits = ^{w_offset[31:20], w_offset[1:0]};

  sram_phase_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .i_clr(r_state == ST_IDLE),
    .i_en (w_in_phase),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_write  <= 1'b0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_addr   <= '0;
      r_we_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_dq_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state  <= ST_LOW;
            r_write  <= wr_en;
            r_word   <= w_offset[19:2];
            r_wdata  <= wdata;
            r_addr   <= half_addr(w_offset[19:2], 1'b0);
            r_we_n   <= ~wr_en;
            r_dq_oe  <= wr_en;
            r_dq_out <= wdata[15:0];
          end
        end
        ST_LOW: begin
          if (w_tc) begin
            r_state  <= ST_HIGH;
            r_addr   <= half_addr(r_word, 1'b1);
            r_dq_out <= r_wdata[31:16];
            if (!r_write) r_rdata[15:0] <= SRAM_DQ;
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            r_state <= ST_DONE;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            if (!r_write) r_rdata[31:16] <= SRAM_DQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SRAM_DQ   = r_dq_oe ? r_dq_out : {SRAM_DW{1'bz}};
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign rdata     = r_rdata;
  assign ready     = ~w_req | (r_state == ST_DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: three controllers (ACCESS_CYCLES 2, 1, 3), each on its own behavioural SRAM.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        wr_en   [3];
  logic        rd_en   [3];
  logic [31:0] address [3];
  logic [31:0] wdata   [3];
  logic [31:0] rdata   [3];
  logic        ready   [3];
  logic [18:0] sa      [3];
  logic        we_n    [3];
  logic        ub_n    [3];
  logic        lb_n    [3];
  logic        ce_n    [3];
  logic        oe_n    [3];
  wire  [15:0] dq0, dq1, dq2;
  logic [15:0] mem [3][64];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ACCESS_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .SRAM_DQ(dq0), .SRAM_ADDR(sa[0]),
    .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]), .SRAM_WE_N(we_n[0]), .SRAM_CE_N(ce_n[0]),
    .SRAM_OE_N(oe_n[0]));

  sram_ctrl #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .SRAM_DQ(dq1), .SRAM_ADDR(sa[1]),
    .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]), .SRAM_WE_N(we_n[1]), .SRAM_CE_N(ce_n[1]),
    .SRAM_OE_N(oe_n[1]));

  sram_ctrl #(.ACCESS_CYCLES(3)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[2]), .rd_en(rd_en[2]), .address(address[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .SRAM_DQ(dq2), .SRAM_ADDR(sa[2]),
    .SRAM_UB_N(ub_n[2]), .SRAM_LB_N(lb_n[2]), .SRAM_WE_N(we_n[2]), .SRAM_CE_N(ce_n[2]),
    .SRAM_OE_N(oe_n[2]));

  // Asynchronous SRAM with OE_N/CE_N tied low: drives DQ whenever WE_N is high.
  assign dq0 = we_n[0] ? mem[0][sa[0][5:0]] : 16'bz;
  assign dq1 = we_n[1] ? mem[1][sa[1][5:0]] : 16'bz;
  assign dq2 = we_n[2] ? mem[2][sa[2][5:0]] : 16'bz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 64; i++) mem[k][i] <= 16'h0;
    end else begin
      if (!we_n[0]) mem[0][sa[0][5:0]] <= dq0;
      if (!we_n[1]) mem[1][sa[1][5:0]] <= dq1;
      if (!we_n[2]) mem[2][sa[2][5:0]] <= dq2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on controller k. Entered at negedge+1 of an IDLE cycle (or of DONE when b2b);
  // returns at negedge+1 of the DONE cycle with the request still applied.
  task automatic run(input int k, input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input bit b2b, input logic [31:0] exp_rd);
    int          ac;
    int          cyc;
    bit          saw_we;
    logic [31:0] off;
    logic [18:0] lo_addr;
    ac      = (k == 0) ? 2 : (k == 1) ? 1 : 3;
    off     = a - 32'd1024;
    lo_addr = {off[19:2], 1'b0};
    saw_we  = 1'b0;
    wr_en[k] = wr; rd_en[k] = rd; address[k] = a; wdata[k] = d;
    if (b2b) @(negedge clk);
    #1;
    chk("ready_cycle0", 32'(ready[k]), 32'd0);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk("addr_low", 32'(sa[k]), 32'(lo_addr));
        chk("we_n_low", 32'(we_n[k]), 32'(!wr));
      end
      if (cyc == ac + 1) chk("addr_high", 32'(sa[k]), 32'(lo_addr | 19'd1));
      if (!wr && !we_n[k]) saw_we = 1'b1;
      if (ready[k]) break;
    end
    chk("stall_cycles", 32'(cyc), 32'(2 * ac + 1));
    if (!wr) begin
      chk("rdata", rdata[k], exp_rd);
      chk("read_no_we", 32'(saw_we), 32'd0);
    end
  endtask

  task automatic idle(input int k);
    wr_en[k] = 1'b0; rd_en[k] = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_en[k] = 1'b0; rd_en[k] = 1'b0; address[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    chk("rst_ready", 32'(ready[0]), 32'd1);
    chk("rst_we_n", 32'(we_n[0]), 32'd1);
    chk("rst_addr", 32'(sa[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("tied_n", {28'd0, ub_n[0], lb_n[0], ce_n[0], oe_n[0]}, 32'd0);

    // Store then load at the base address.
    run(0, 1'b1, 1'b0, 32'd1024, 32'h1234_5678, 1'b0, 32'h0);
    chk("done_ready", 32'(ready[0]), 32'd1);
    idle(0);
    chk("idle_ready", 32'(ready[0]), 32'd1);
    chk("mem0", 32'(mem[0][0]), 32'h5678);
    chk("mem1", 32'(mem[0][1]), 32'h1234);
    run(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'h1234_5678);
    idle(0);

    // Back-to-back store and load through a single IDLE cycle.
    run(0, 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run(0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, 32'hDEAD_BEEF);
    idle(0);
    chk("mem2", 32'(mem[0][2]), 32'hBEEF);
    chk("mem3", 32'(mem[0][3]), 32'hDEAD);

    // Both requests high: write wins, rdata untouched.
    run(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A, 1'b0, 32'h0);
    idle(0);
    chk("both_mem4", 32'(mem[0][4]), 32'h5A5A);
    chk("both_mem5", 32'(mem[0][5]), 32'hA5A5);
    chk("both_rdata", rdata[0], 32'hDEAD_BEEF);

    // Reset in the first HIGH cycle of a store to 1036.
    wr_en[0] = 1'b1; address[0] = 32'd1036; wdata[0] = 32'h1111_2222;
    repeat (3) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_we_n", 32'(we_n[0]), 32'd1);
    chk("mid_rst_addr", 32'(sa[0]), 32'd0);
    chk("mid_rst_rdata", rdata[0], 32'd0);
    chk("mid_rst_ready_req", 32'(ready[0]), 32'd0);
    rst = 1'b0; wr_en[0] = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready[0]), 32'd1);
    chk("mid_rst_mem6", 32'(mem[0][6]), 32'h2222);
    @(negedge clk); #1;
    run(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'h1234_5678);
    idle(0);

    // ACCESS_CYCLES = 1
    run(1, 1'b1, 1'b0, 32'd1024, 32'hCAFE_F00D, 1'b0, 32'h0);
    idle(1);
    chk("ac1_mem0", 32'(mem[1][0]), 32'hF00D);
    chk("ac1_mem1", 32'(mem[1][1]), 32'hCAFE);
    run(1, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'hCAFE_F00D);
    idle(1);

    // ACCESS_CYCLES = 3
    run(2, 1'b1, 1'b0, 32'd1040, 32'h0BAD_C0DE, 1'b0, 32'h0);
    idle(2);
    chk("ac3_mem8", 32'(mem[2][8]), 32'hC0DE);
    chk("ac3_mem9", 32'(mem[2][9]), 32'h0BAD);
    run(2, 1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, 32'h0BAD_C0DE);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
